// File: rtl/tx_axis_arb_if.sv
// -----------------------------------------------------------------------------
// tx_axis_arb_if
// One 32-bit AXI-Stream link as used on the 10G TX PCS input.
//   tdata  : 32-bit beat data
//   tvldb  : valid-byte code on the last beat (0 = 4 bytes, 1..3 = that many)
//   tvalid : beat valid (driven by master)
//   tready : beat accepted (driven by slave)
//   tlast  : end of frame
//   tuser  : error/abort flag
// Modports:
//   master : drives the stream (tdata/tvldb/tvalid/tlast/tuser), samples tready
//   slave  : samples the stream, drives tready
// -----------------------------------------------------------------------------
interface tx_axis_arb_if;
    logic [31:0] tdata;
    logic [1:0]  tvldb;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;

    modport master (
        output tdata,
        output tvldb,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvldb,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/tx_axis_arb.sv
// -----------------------------------------------------------------------------
// tx_axis_arb
// Frame-level round-robin arbiter sharing the single AXIS input of the 10G TX
// PCS between two frame sources. The grant is locked for a whole frame, frames
// longer than MAX_FRAME_BEATS are cut with an abort marker (tlast+tuser, tvldb=0)
// and the rest of the source frame is drained. An in-order owner FIFO routes
// each per-frame TX status response back to the source that sent the frame.
//
// Ports:
//   clk_i, rst_n_i        : PCS TX clock, asynchronous active-low reset
//   s0, s1 (slave)        : source streams
//   m (master)            : stream towards the PCS TX
//   tx_status_i           : per-frame status from the PCS TX
//   tx_rsp_valid_i        : status strobe, one per frame, in frame order
//   s0/s1_status_o        : routed status (registered, 1-cycle latency)
//   s0/s1_rsp_valid_o     : routed status strobe
//   grant_o               : one-hot current owner, 00 when idle
//   trunc_o               : pulse in the cycle after a truncating beat transfers
//   orphan_rsp_o          : sticky, a response arrived with no frame in flight
// -----------------------------------------------------------------------------
module tx_axis_arb #(
    parameter int MAX_FRAME_BEATS = 384,
    parameter int OWNER_DEPTH     = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    tx_axis_arb_if.slave  s0,
    tx_axis_arb_if.slave  s1,
    tx_axis_arb_if.master m,
    input  logic          tx_status_i,
    input  logic          tx_rsp_valid_i,
    output logic          s0_status_o,
    output logic          s0_rsp_valid_o,
    output logic          s1_status_o,
    output logic          s1_rsp_valid_o,
    output logic [1:0]    grant_o,
    output logic          trunc_o,
    output logic          orphan_rsp_o
);

    localparam int                PTR_W     = (OWNER_DEPTH > 1) ? $clog2(OWNER_DEPTH) : 1;
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(OWNER_DEPTH);
    localparam logic [11:0]       LAST_BEAT = 12'(MAX_FRAME_BEATS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DRAIN} state_t;

    state_t             state_reg, state_next;
    logic               grant_id_reg, grant_id_next;
    logic               last_reg, last_next;
    logic [11:0]        beat_cnt_reg;
    logic               push, pick;

    logic               owner_mem [OWNER_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               fifo_full, fifo_empty, pop, head_id;

    // Granted source, muxed once so the FSM and datapath share it.
    logic [31:0]        sel_tdata;
    logic [1:0]         sel_tvldb;
    logic               sel_tvalid, sel_tlast, sel_tuser;
    logic               xfer, trunc_beat;

    assign sel_tdata  = grant_id_reg ? s1.tdata  : s0.tdata;
    assign sel_tvldb  = grant_id_reg ? s1.tvldb  : s0.tvldb;
    assign sel_tvalid = grant_id_reg ? s1.tvalid : s0.tvalid;
    assign sel_tlast  = grant_id_reg ? s1.tlast  : s0.tlast;
    assign sel_tuser  = grant_id_reg ? s1.tuser  : s0.tuser;

    assign xfer       = (state_reg == ST_PASS) && sel_tvalid && m.tready;
    // A source tlast on the final allowed beat is a normal end, not a cut.
    assign trunc_beat = (state_reg == ST_PASS) && (beat_cnt_reg == LAST_BEAT) && !sel_tlast;

    assign fifo_full  = (count_reg == FIFO_FULL);
    assign fifo_empty = (count_reg == '0);
    assign pop        = tx_rsp_valid_i && !fifo_empty;
    assign head_id    = owner_mem[rd_ptr_reg];

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg    <= ST_IDLE;
            grant_id_reg <= 1'b0;
            last_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            grant_id_reg <= grant_id_next;
            last_reg     <= last_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next    = state_reg;
        grant_id_next = grant_id_reg;
        last_next     = last_reg;
        push          = 1'b0;
        pick          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if ((s0.tvalid || s1.tvalid) && !fifo_full) begin
                    pick          = (s0.tvalid && s1.tvalid) ? ~last_reg : s1.tvalid;
                    grant_id_next = pick;
                    last_next     = pick;
                    push          = 1'b1;
                    state_next    = ST_PASS;
                end
            end
            ST_PASS: begin
                if (xfer) begin
                    if (sel_tlast)       state_next = ST_IDLE;
                    else if (trunc_beat) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sel_tvalid && sel_tlast) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        m.tdata   = '0;
        m.tvldb   = '0;
        m.tvalid  = 1'b0;
        m.tlast   = 1'b0;
        m.tuser   = 1'b0;
        s0.tready = 1'b0;
        s1.tready = 1'b0;
        grant_o   = 2'b00;
        case (state_reg)
            ST_PASS: begin
                m.tdata  = sel_tdata;
                m.tvldb  = trunc_beat ? 2'd0 : sel_tvldb;
                m.tvalid = sel_tvalid;
                m.tlast  = sel_tlast | trunc_beat;
                m.tuser  = sel_tuser | trunc_beat;
                if (grant_id_reg) s1.tready = m.tready;
                else              s0.tready = m.tready;
                grant_o  = grant_id_reg ? 2'b10 : 2'b01;
            end
            ST_DRAIN: begin
                // Remaining source beats are swallowed; nothing reaches the PCS.
                if (grant_id_reg) s1.tready = 1'b1;
                else              s0.tready = 1'b1;
                grant_o  = grant_id_reg ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    // ---------------- beat counter ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            beat_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            beat_cnt_reg <= '0;
        end else if (xfer) begin
            beat_cnt_reg <= beat_cnt_reg + 12'd1;
        end
    end

    // ---------------- owner FIFO storage ----------------
    always_ff @(posedge clk_i) begin
        if (push) owner_mem[wr_ptr_reg] <= pick;
    end

    // ---------------- owner FIFO control and response routing ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            s0_rsp_valid_o <= 1'b0;
            s0_status_o    <= 1'b0;
            s1_rsp_valid_o <= 1'b0;
            s1_status_o    <= 1'b0;
            orphan_rsp_o   <= 1'b0;
            trunc_o        <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            s0_rsp_valid_o <= pop && !head_id;
            s0_status_o    <= pop && !head_id && tx_status_i;
            s1_rsp_valid_o <= pop && head_id;
            s1_status_o    <= pop && head_id && tx_status_i;
            if (tx_rsp_valid_i && fifo_empty) orphan_rsp_o <= 1'b1;
            trunc_o        <= xfer && trunc_beat;
        end
    end

endmodule

// File: tb/tb_tx_axis_arb.sv
// -----------------------------------------------------------------------------
// tb_tx_axis_arb
// Directed phases with randomized data, valid gaps and backpressure. A frame-
// level reference model (per-source beat queues, owner queue, round-robin rule)
// predicts grant, readies, master beats and routed responses every cycle.
// -----------------------------------------------------------------------------
module tb_tx_axis_arb;

    localparam int MAXB  = 8;
    localparam int DEPTH = 4;

    logic clk_i = 1'b0;
    logic rst_n_i;
    always #5 clk_i = ~clk_i;

    tx_axis_arb_if s0_if ();
    tx_axis_arb_if s1_if ();
    tx_axis_arb_if m_if ();

    logic       tx_status_i, tx_rsp_valid_i;
    logic       s0_status_o, s0_rsp_valid_o, s1_status_o, s1_rsp_valid_o;
    logic [1:0] grant_o;
    logic       trunc_o, orphan_rsp_o;

    tx_axis_arb #(
        .MAX_FRAME_BEATS(MAXB),
        .OWNER_DEPTH    (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .s0             (s0_if),
        .s1             (s1_if),
        .m              (m_if),
        .tx_status_i    (tx_status_i),
        .tx_rsp_valid_i (tx_rsp_valid_i),
        .s0_status_o    (s0_status_o),
        .s0_rsp_valid_o (s0_rsp_valid_o),
        .s1_status_o    (s1_status_o),
        .s1_rsp_valid_o (s1_rsp_valid_o),
        .grant_o        (grant_o),
        .trunc_o        (trunc_o),
        .orphan_rsp_o   (orphan_rsp_o)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  v;
        logic        l;
        logic        u;
    } beat_t;

    int    vectors = 0;
    int    miscompares = 0;

    // stimulus state
    beat_t sq [2][$];
    bit    vld [2];
    int    src_rate = 100;
    int    rdy_rate = 100;
    bit    rdy_pat [$];
    bit    rsp_req = 1'b0;
    bit    rsp_stat = 1'b0;

    // reference model
    int    own = -1;
    int    last_id = 1;
    int    beat_idx = 0;
    bit    dr = 1'b0;
    int    oq [$];
    bit    exp_r0, exp_s0, exp_r1, exp_s1, exp_orphan;
    int    trunc_exp = 0;
    int    trunc_seen = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input int src, input int len, input logic [1:0] lv, input logic lu);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = $urandom;
            b.l = (k == len - 1);
            b.v = b.l ? lv : 2'd0;
            b.u = b.l ? lu : 1'b0;
            sq[src].push_back(b);
        end
    endtask

    task automatic drive_srcs();
        beat_t b0, b1;
        b0 = (sq[0].size() > 0) ? sq[0][0] : '0;
        b1 = (sq[1].size() > 0) ? sq[1][0] : '0;
        s0_if.tvalid = vld[0];
        s0_if.tdata  = b0.d;
        s0_if.tvldb  = b0.v;
        s0_if.tlast  = b0.l;
        s0_if.tuser  = b0.u;
        s1_if.tvalid = vld[1];
        s1_if.tdata  = b1.d;
        s1_if.tvldb  = b1.v;
        s1_if.tlast  = b1.l;
        s1_if.tuser  = b1.u;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic tick();
        beat_t      fb;
        bit         mr, mv_exp;
        bit         r_exp [2];
        logic [1:0] g_exp;
        int         pre, id, pick;

        for (int i = 0; i < 2; i++)
            if (!vld[i] && sq[i].size() > 0 && $urandom_range(99) < src_rate) vld[i] = 1'b1;
        drive_srcs();
        if (rdy_pat.size() > 0) mr = rdy_pat.pop_front();
        else                    mr = ($urandom_range(99) < rdy_rate);
        m_if.tready    = mr;
        tx_rsp_valid_i = rsp_req;
        tx_status_i    = rsp_stat;
        #1;

        g_exp = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
        for (int i = 0; i < 2; i++) r_exp[i] = (own == i) ? (dr ? 1'b1 : mr) : 1'b0;
        mv_exp = (own >= 0) && !dr && vld[own];

        check("grant", 64'(grant_o), 64'(g_exp));
        check("s0_ready", 64'(s0_if.tready), 64'(r_exp[0]));
        check("s1_ready", 64'(s1_if.tready), 64'(r_exp[1]));
        check("m_valid", 64'(m_if.tvalid), 64'(mv_exp));
        check("rsp", 64'({s0_rsp_valid_o, s0_status_o, s1_rsp_valid_o, s1_status_o}),
              64'({exp_r0, exp_s0, exp_r1, exp_s1}));
        check("orphan", 64'(orphan_rsp_o), 64'(exp_orphan));
        if (mv_exp && mr) begin
            fb = sq[own][0];
            if (beat_idx == MAXB - 1 && !fb.l)
                check("m_beat", 64'({m_if.tdata, m_if.tvldb, m_if.tlast, m_if.tuser}),
                      64'({fb.d, 2'd0, 1'b1, 1'b1}));
            else
                check("m_beat", 64'({m_if.tdata, m_if.tvldb, m_if.tlast, m_if.tuser}),
                      64'({fb.d, fb.v, fb.l, fb.u}));
        end
        if (trunc_o) trunc_seen++;

        // model update for the coming edge
        pre    = oq.size();
        exp_r0 = 1'b0; exp_s0 = 1'b0; exp_r1 = 1'b0; exp_s1 = 1'b0;
        if (rsp_req) begin
            if (pre > 0) begin
                id = oq.pop_front();
                if (id == 0) begin exp_r0 = 1'b1; exp_s0 = rsp_stat; end
                else         begin exp_r1 = 1'b1; exp_s1 = rsp_stat; end
            end else begin
                exp_orphan = 1'b1;
            end
        end
        if (own >= 0) begin
            if (vld[own] && r_exp[own]) begin
                fb = sq[own].pop_front();
                vld[own] = 1'b0;
                if (fb.l) begin
                    own = -1;
                    dr  = 1'b0;
                end else begin
                    if (!dr && beat_idx == MAXB - 1) begin
                        dr = 1'b1;
                        trunc_exp++;
                    end
                    beat_idx++;
                end
            end
        end else if ((vld[0] || vld[1]) && pre < DEPTH) begin
            pick     = (vld[0] && vld[1]) ? (1 - last_id) : (vld[1] ? 1 : 0);
            own      = pick;
            last_id  = pick;
            oq.push_back(pick);
            beat_idx = 0;
            dr       = 1'b0;
        end
        rsp_req = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((sq[0].size() > 0 || sq[1].size() > 0 || own >= 0) && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 64'(sq[0].size() + sq[1].size() + ((own >= 0) ? 1 : 0)), 64'(0));
        tick();
        tick();
    endtask

    task automatic respond(input bit stat);
        rsp_req  = 1'b1;
        rsp_stat = stat;
        tick();
    endtask

    task automatic drain_rsp();
        while (oq.size() > 0) respond(1'($urandom_range(1)));
        tick();
    endtask

    // Asserts reset away from the clock edge and checks outputs clear at once.
    task automatic do_reset();
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_grant", 64'(grant_o), 64'(0));
        check("rst_ready", 64'({s0_if.tready, s1_if.tready}), 64'(0));
        check("rst_mvalid", 64'(m_if.tvalid), 64'(0));
        check("rst_rsp", 64'({s0_rsp_valid_o, s0_status_o, s1_rsp_valid_o, s1_status_o}), 64'(0));
        check("rst_orphan", 64'(orphan_rsp_o), 64'(0));
        check("rst_trunc", 64'(trunc_o), 64'(0));
        own = -1; last_id = 1; beat_idx = 0; dr = 1'b0;
        oq.delete();
        sq[0].delete();
        sq[1].delete();
        vld[0] = 1'b0; vld[1] = 1'b0;
        exp_r0 = 1'b0; exp_s0 = 1'b0; exp_r1 = 1'b0; exp_s1 = 1'b0; exp_orphan = 1'b0;
        trunc_exp = 0; trunc_seen = 0;
        rdy_pat.delete();
        drive_srcs();
        m_if.tready    = 1'b0;
        tx_rsp_valid_i = 1'b0;
        tx_status_i    = 1'b0;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
    endtask

    initial begin
        int n;
        rst_n_i        = 1'b0;
        m_if.tready    = 1'b0;
        tx_rsp_valid_i = 1'b0;
        tx_status_i    = 1'b0;
        vld[0] = 1'b0; vld[1] = 1'b0;
        drive_srcs();
        do_reset();

        // single source frame, full throughput
        src_rate = 100; rdy_rate = 100;
        add_frame(0, 4, 2'd2, 1'b0);
        run_until_idle(50);
        drain_rsp();

        // both sources busy: strict alternation starting from s0
        do_reset();
        for (int k = 0; k < 2; k++) begin
            add_frame(0, 3, 2'($urandom_range(3)), 1'b0);
            add_frame(1, 3, 2'($urandom_range(3)), 1'b0);
        end
        run_until_idle(80);
        drain_rsp();

        // master backpressure 1,0,0,1 mid-frame
        rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        add_frame(1, 5, 2'd3, 1'b1);
        run_until_idle(50);
        drain_rsp();

        // oversized frame is cut at MAXB beats and drained
        add_frame(1, 12, 2'd1, 1'b0);
        run_until_idle(60);
        check("trunc_count", 64'(trunc_seen), 64'(trunc_exp));
        drain_rsp();

        // response routing s0,s1,s1 then an orphan strobe
        add_frame(0, 2, 2'd0, 1'b0);
        add_frame(1, 3, 2'd2, 1'b0);
        add_frame(1, 2, 2'd1, 1'b0);
        run_until_idle(60);
        respond(1'b1);
        respond(1'b0);
        respond(1'b1);
        respond(1'b0);
        tick();
        check("orphan_sticky", 64'(orphan_rsp_o), 64'(1));

        // full owner FIFO stalls the next grant until a response pops
        for (int k = 0; k < 2; k++) begin
            add_frame(0, 2, 2'd0, 1'b0);
            add_frame(1, 2, 2'd0, 1'b0);
        end
        run_until_idle(60);
        add_frame(0, 2, 2'd3, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        respond(1'b1);
        run_until_idle(40);
        drain_rsp();

        // randomized traffic with gaps, backpressure and interleaved responses
        for (int f = 0; f < 24; f++)
            add_frame($urandom_range(1), $urandom_range(1, 12), 2'($urandom_range(3)), 1'($urandom_range(1)));
        src_rate = $urandom_range(40, 100);
        rdy_rate = $urandom_range(50, 100);
        n = 0;
        while ((sq[0].size() > 0 || sq[1].size() > 0 || own >= 0) && n < 3000) begin
            rsp_req  = (oq.size() > 0) && ($urandom_range(99) < 25);
            rsp_stat = 1'($urandom_range(1));
            tick();
            n++;
        end
        check("rand_timeout", 64'(sq[0].size() + sq[1].size() + ((own >= 0) ? 1 : 0)), 64'(0));
        tick();
        tick();
        check("rand_trunc_count", 64'(trunc_seen), 64'(trunc_exp));
        drain_rsp();

        // reset in the middle of a passing frame
        src_rate = 100; rdy_rate = 100;
        add_frame(1, 6, 2'd0, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        do_reset();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
